// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// decoded instruction classes, ALU operation codes, PC source selects and MIPS-I fields.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE,
    CLS_J, CLS_JR, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BNE = 4'd11;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational instruction decoder: opcode/funct to class, ALU operation,
// immediate select and halfword flag. Anything unmatched decodes as illegal.
module mc_decode
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int HALF_EN = 1
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output instr_class_t       instr_class,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_b,
  output logic               half,
  output logic               illegal
);

  logic [3:0] alu_code;

  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_code    = ALU_NOP;
    alu_src_b   = 1'b0;
    half        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin instr_class = CLS_ALU; alu_code = ALU_ADD; end
          FN_SUB:  begin instr_class = CLS_ALU; alu_code = ALU_SUB; end
          FN_AND:  begin instr_class = CLS_ALU; alu_code = ALU_AND; end
          FN_OR:   begin instr_class = CLS_ALU; alu_code = ALU_OR;  end
          FN_XOR:  begin instr_class = CLS_ALU; alu_code = ALU_XOR; end
          FN_NOR:  begin instr_class = CLS_ALU; alu_code = ALU_NOR; end
          FN_SLT:  begin instr_class = CLS_ALU; alu_code = ALU_SLT; end
          FN_SLL:  begin instr_class = CLS_ALU; alu_code = ALU_SLL; end
          FN_SRL:  begin instr_class = CLS_ALU; alu_code = ALU_SRL; end
          FN_JR:   instr_class = CLS_JR;
          FN_JALR: instr_class = CLS_JALR;
          default: instr_class = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: begin instr_class = CLS_ALU;   alu_code = ALU_ADD; alu_src_b = 1'b1; end
      OP_ANDI: begin instr_class = CLS_ALU;   alu_code = ALU_AND; alu_src_b = 1'b1; end
      OP_SLTI: begin instr_class = CLS_ALU;   alu_code = ALU_SLT; alu_src_b = 1'b1; end
      OP_BEQ:  begin instr_class = CLS_BEQ;   alu_code = ALU_BEQ; end
      OP_BNE:  begin instr_class = CLS_BNE;   alu_code = ALU_BNE; end
      OP_LW:   begin instr_class = CLS_LOAD;  alu_code = ALU_ADD; alu_src_b = 1'b1; end
      OP_SW:   begin instr_class = CLS_STORE; alu_code = ALU_ADD; alu_src_b = 1'b1; end
      // Halfword accesses only exist when the datapath supports them.
      OP_LH: if (HALF_EN != 0) begin
        instr_class = CLS_LOAD;  alu_code = ALU_ADD; alu_src_b = 1'b1; half = 1'b1;
      end
      OP_SH: if (HALF_EN != 0) begin
        instr_class = CLS_STORE; alu_code = ALU_ADD; alu_src_b = 1'b1; half = 1'b1;
      end
      OP_J:    instr_class = CLS_J;
      OP_JAL:  instr_class = CLS_JAL;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

  assign alu_op  = ALUOP_W'(alu_code);
  assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with a retired-instruction
// counter. Opcode/funct are expected stable from DECODE until the instruction retires.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int HALF_EN = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_half,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_b,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               reg_write,
  output logic               mem2reg,
  output logic               link,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired
);

  // Memory handshake: mem_req is held high in FETCH/MEM; a transfer completes on
  // the rising edge where mem_req && mem_ready, and the FSM advances on that edge.

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q;
  instr_class_t       dec_class;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_alu_src_b, dec_half, dec_illegal;

  logic               mem_req_c, mem_we_c, mem_half_c, ir_write_c, pc_write_c;
  logic               alu_src_b_c, reg_write_c, mem2reg_c, link_c, illegal_c, retire;
  logic [1:0]         pc_src_c;
  logic [ALUOP_W-1:0] alu_op_c;

  mc_decode #(.ALUOP_W(ALUOP_W), .HALF_EN(HALF_EN)) u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .alu_src_b   (dec_alu_src_b),
    .half        (dec_half),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_half_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = PC_SEQ;
    alu_src_b_c = 1'b0;
    alu_op_c    = '0;
    reg_write_c = 1'b0;
    mem2reg_c   = 1'b0;
    link_c      = 1'b0;
    illegal_c   = 1'b0;
    retire      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_c = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op_c    = dec_alu_op;
        alu_src_b_c = dec_alu_src_b;
        case (dec_class)
          CLS_ALU:             state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BEQ:  begin pc_write_c = zero;  pc_src_c = PC_BRANCH; retire = 1'b1; state_d = ST_FETCH; end
          CLS_BNE:  begin pc_write_c = !zero; pc_src_c = PC_BRANCH; retire = 1'b1; state_d = ST_FETCH; end
          CLS_J:    begin pc_write_c = 1'b1;  pc_src_c = PC_JUMP;   retire = 1'b1; state_d = ST_FETCH; end
          CLS_JR:   begin pc_write_c = 1'b1;  pc_src_c = PC_REG;    retire = 1'b1; state_d = ST_FETCH; end
          CLS_JAL:  begin pc_write_c = 1'b1;  pc_src_c = PC_JUMP;   state_d = ST_WB; end
          CLS_JALR: begin pc_write_c = 1'b1;  pc_src_c = PC_REG;    state_d = ST_WB; end
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req_c  = 1'b1;
        mem_we_c   = (dec_class == CLS_STORE);
        mem_half_c = dec_half;
        if (mem_ready) begin
          if (dec_class == CLS_STORE) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write_c = 1'b1;
        mem2reg_c   = (dec_class == CLS_LOAD);
        link_c      = (dec_class == CLS_JAL) || (dec_class == CLS_JALR);
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset silences every control output immediately, abandoning any pending request.
  assign mem_req   = mem_req_c   & ~rst;
  assign mem_we    = mem_we_c    & ~rst;
  assign mem_half  = mem_half_c  & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign pc_write  = pc_write_c  & ~rst;
  assign pc_src    = rst ? 2'b00 : pc_src_c;
  assign alu_src_b = alu_src_b_c & ~rst;
  assign ALUOp     = rst ? '0 : alu_op_c;
  assign reg_write = reg_write_c & ~rst;
  assign mem2reg   = mem2reg_c   & ~rst;
  assign link      = link_c      & ~rst;
  assign illegal   = illegal_c   & ~rst;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (halfword on/off), a table-driven
// instruction model producing per-cycle expected outputs into queues, and a negedge monitor.
module tb_multicycle_controller;

  localparam int AW = 4;
  localparam int CW = 4;
  localparam int OW = 3 + 5 + 2 + 1 + AW + 4;
  localparam int W  = OW + CW;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BEQ = 3, K_BNE = 4;
  localparam int K_J = 5, K_JR = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode_a = '0, funct_a = '0, opcode_b = '0, funct_b = '0;
  logic zero_a = 1'b0, mem_ready_a = 1'b0, zero_b = 1'b0, mem_ready_b = 1'b0;
  logic mem_req_a, mem_we_a, mem_half_a, ir_write_a, pc_write_a, alu_src_b_a;
  logic reg_write_a, mem2reg_a, link_a, illegal_a;
  logic mem_req_b, mem_we_b, mem_half_b, ir_write_b, pc_write_b, alu_src_b_b;
  logic reg_write_b, mem2reg_b, link_b, illegal_b;
  logic [1:0] pc_src_a, pc_src_b;
  logic [AW-1:0] aluop_a, aluop_b;
  logic [2:0] state_a, state_b;
  logic [CW-1:0] retired_a, retired_b;

  multicycle_controller #(.ALUOP_W(AW), .HALF_EN(1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode_a), .funct(funct_a), .zero(zero_a),
    .mem_ready(mem_ready_a), .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_half(mem_half_a),
    .ir_write(ir_write_a), .pc_write(pc_write_a), .pc_src(pc_src_a), .alu_src_b(alu_src_b_a),
    .ALUOp(aluop_a), .reg_write(reg_write_a), .mem2reg(mem2reg_a), .link(link_a),
    .illegal(illegal_a), .state(state_a), .retired(retired_a));

  multicycle_controller #(.ALUOP_W(AW), .HALF_EN(0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode_b), .funct(funct_b), .zero(zero_b),
    .mem_ready(mem_ready_b), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_half(mem_half_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .pc_src(pc_src_b), .alu_src_b(alu_src_b_b),
    .ALUOp(aluop_b), .reg_write(reg_write_b), .mem2reg(mem2reg_b), .link(link_b),
    .illegal(illegal_b), .state(state_b), .retired(retired_b));

  logic [W-1:0] obs_a, obs_b;
  assign obs_a = {state_a, mem_req_a, mem_we_a, mem_half_a, ir_write_a, pc_write_a, pc_src_a,
                  alu_src_b_a, aluop_a, reg_write_a, mem2reg_a, link_a, illegal_a, retired_a};
  assign obs_b = {state_b, mem_req_b, mem_we_b, mem_half_b, ir_write_b, pc_write_b, pc_src_b,
                  alu_src_b_b, aluop_b, reg_write_b, mem2reg_b, link_b, illegal_b, retired_b};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  typedef struct {
    logic [5:0]    op;
    logic [5:0]    fn;
    int            kind;
    logic [AW-1:0] aop;
    bit            imm;
    bit            half;
  } ins_t;
  ins_t tbl[$];

  function automatic ins_t lookup(input logic [5:0] op, input logic [5:0] fn, input bit half_en);
    ins_t r;
    r = '{op, fn, K_ILL, '0, 1'b0, 1'b0};
    foreach (tbl[i])
      if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn) && (!tbl[i].half || half_en))
        r = tbl[i];
    return r;
  endfunction

  function automatic logic [OW-1:0] ob(input logic [2:0] st, input bit req, input bit we,
      input bit hf, input bit irw, input bit pcw, input logic [1:0] src, input bit imm,
      input logic [AW-1:0] aop, input bit rw, input bit m2r, input bit lnk, input bit ill);
    return {st, req, we, hf, irw, pcw, src, imm, aop, rw, m2r, lnk, ill};
  endfunction

  // Monitor: every cycle with a pending expectation is compared.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL dut_a cycle_obs t=%0t got=%h expected=%h", $time, obs_a, e);
      end
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      n_vec++;
      if (obs_b !== e) begin
        n_fail++;
        $display("FAIL dut_b cycle_obs t=%0t got=%h expected=%h", $time, obs_b, e);
      end
    end
  end

  task automatic cyc(input int d, input logic [5:0] op, input logic [5:0] fn, input bit z,
                     input bit rdy, input bit rst_v, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = rst_v;
    if (d == 0) begin
      opcode_a = op; funct_a = fn; zero_a = z; mem_ready_a = rdy; mem_ready_b = 1'b0;
      exp_q.push_back(e);
    end else begin
      opcode_b = op; funct_b = fn; zero_b = z; mem_ready_b = rdy; mem_ready_a = 1'b0;
      exp_b_q.push_back(e);
    end
  endtask

  // Executes one instruction on DUT d; abort_at >= 0 asserts reset at that cycle index.
  task automatic run_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit zv, input int abort_at);
    ins_t ins;
    logic [OW+1:0] pl[$];
    logic [OW+1:0] p;
    logic [2:0] st;
    logic [1:0] src;
    bit pcw;
    int c;
    ins = lookup(op, fn, d == 0);
    c = (d == 0) ? cnt_a : cnt_b;
    for (int i = 0; i < fw; i++) pl.push_back({1'b0, 1'b0, ob(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    pl.push_back({1'b0, 1'b1, ob(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)});
    pl.push_back({1'b1, bit'($urandom_range(0, 1)), ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ins.kind == K_ILL)});
    if (ins.kind != K_ILL) begin
      pcw = 1'b0;
      src = 2'd0;
      case (ins.kind)
        K_BEQ:        begin pcw = zv;  src = 2'd1; end
        K_BNE:        begin pcw = !zv; src = 2'd1; end
        K_J, K_JAL:   begin pcw = 1'b1; src = 2'd2; end
        K_JR, K_JALR: begin pcw = 1'b1; src = 2'd3; end
        default: ;
      endcase
      pl.push_back({1'b1, bit'($urandom_range(0, 1)), ob(2, 0, 0, 0, 0, pcw, src, ins.imm, ins.aop, 0, 0, 0, 0)});
      if (ins.kind == K_LD || ins.kind == K_ST) begin
        for (int i = 0; i < mw; i++)
          pl.push_back({1'b1, 1'b0, ob(3, 1, ins.kind == K_ST, ins.half, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        pl.push_back({1'b1, 1'b1, ob(3, 1, ins.kind == K_ST, ins.half, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      end
      if (ins.kind == K_ALU || ins.kind == K_LD || ins.kind == K_JAL || ins.kind == K_JALR)
        pl.push_back({1'b1, bit'($urandom_range(0, 1)),
                      ob(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, ins.kind == K_LD,
                         ins.kind == K_JAL || ins.kind == K_JALR, 0)});
    end
    for (int i = 0; i < pl.size(); i++) begin
      p = pl[i];
      st = p[OW-1 -: 3];
      if (i == abort_at) begin
        cyc(d, 6'($urandom), 6'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1,
            {st, (OW-3)'(0), CW'(c)});
        cyc(d, 6'($urandom), 6'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1,
            W'(0));
        cnt_a = 0;
        cnt_b = 0;
        return;
      end
      cyc(d, p[OW+1] ? op : 6'($urandom), p[OW+1] ? fn : 6'($urandom),
          (st == 3'd2) ? zv : bit'($urandom_range(0, 1)), p[OW], 1'b0, {p[OW-1:0], CW'(c)});
    end
    if (ins.kind != K_ILL) c = (c + 1) % (1 << CW);
    if (d == 0) cnt_a = c; else cnt_b = c;
  endtask

  task automatic run_random(input int d, input int n);
    int k;
    logic [5:0] op, fn;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 85) begin
        k = $urandom_range(0, tbl.size() - 1);
        op = tbl[k].op;
        fn = (op == 6'h00) ? tbl[k].fn : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(d, op, fn, $urandom_range(0, 2), $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
    end
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    tbl.push_back('{6'h00, 6'h20, K_ALU, 4'd1, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h22, K_ALU, 4'd2, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h24, K_ALU, 4'd3, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h25, K_ALU, 4'd4, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h26, K_ALU, 4'd5, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h27, K_ALU, 4'd6, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h2A, K_ALU, 4'd7, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h00, K_ALU, 4'd8, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h02, K_ALU, 4'd9, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h08, K_JR, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{6'h00, 6'h09, K_JALR, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{6'h08, 6'h00, K_ALU, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{6'h0C, 6'h00, K_ALU, 4'd3, 1'b1, 1'b0});
    tbl.push_back('{6'h0A, 6'h00, K_ALU, 4'd7, 1'b1, 1'b0});
    tbl.push_back('{6'h04, 6'h00, K_BEQ, 4'd10, 1'b0, 1'b0});
    tbl.push_back('{6'h05, 6'h00, K_BNE, 4'd11, 1'b0, 1'b0});
    tbl.push_back('{6'h23, 6'h00, K_LD, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{6'h2B, 6'h00, K_ST, 4'd1, 1'b1, 1'b0});
    tbl.push_back('{6'h21, 6'h00, K_LD, 4'd1, 1'b1, 1'b1});
    tbl.push_back('{6'h29, 6'h00, K_ST, 4'd1, 1'b1, 1'b1});
    tbl.push_back('{6'h02, 6'h00, K_J, 4'd0, 1'b0, 1'b0});
    tbl.push_back('{6'h03, 6'h00, K_JAL, 4'd0, 1'b0, 1'b0});

    // Reset: both instances must show FETCH, silent outputs, zero count.
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.push_back(W'(0));
      exp_b_q.push_back(W'(0));
    end

    // Halfword-disabled instance: lh/sh illegal, others still legal.
    run_instr(1, 6'h29, 6'h00, 0, 1, 1'b0, -1);
    run_instr(1, 6'h21, 6'h00, 1, 0, 1'b0, -1);
    run_instr(1, 6'h2B, 6'h00, 0, 2, 1'b0, -1);
    run_instr(1, 6'h00, 6'h20, 0, 0, 1'b0, -1);
    run_random(1, 20);

    // Directed sequences on the halfword-enabled instance.
    run_instr(0, 6'h00, 6'h20, 0, 0, 1'b0, -1);
    run_instr(0, 6'h23, 6'h00, 0, 3, 1'b0, -1);
    run_instr(0, 6'h04, 6'h00, 0, 0, 1'b0, -1);
    run_instr(0, 6'h04, 6'h00, 0, 0, 1'b1, -1);
    run_instr(0, 6'h05, 6'h00, 1, 0, 1'b1, -1);
    run_instr(0, 6'h03, 6'h00, 0, 0, 1'b0, -1);
    run_instr(0, 6'h00, 6'h09, 0, 0, 1'b0, -1);
    run_instr(0, 6'h29, 6'h00, 0, 2, 1'b0, -1);
    run_instr(0, 6'h2B, 6'h00, 0, 3, 1'b0, 4);
    for (int i = 0; i < 17; i++) run_instr(0, 6'h00, 6'h20, 0, 0, 1'b0, -1);
    run_random(0, 160);

    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending a=%0d b=%0d required 0", exp_q.size(), exp_b_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
